// File: rtl/sram_mem_ctrl.sv
// Data-memory controller: splits each 32-bit load/store into two 16-bit
// SRAM half-word accesses, then waits out the SRAM recovery time.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wr_en, rd_en              MEM-stage store / load request (write wins)
//   address, writeData        byte address (data base 1024), store data
//   readData                  registered load result
//   ready                     0 freezes the pipeline while an access runs
//   sram_addr                 half-word address to the SRAM
//   sram_we_n                 active-low SRAM write strobe
//   sram_dq_out, sram_dq_oe   write data and bus-drive enable
//   sram_dq_in                read data from the SRAM bus
module sram_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  cnt;
  logic [1:0]  cnt_nxt;
  logic        op_wr;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] offs;
  logic [16:0] word;
  logic        req;
  logic        unused_offs_bits;

  assign req = wr_en | rd_en;

  // Word index relative to the data base; wraps silently below 1024.
  assign offs = addr_q - 32'd1024;
  assign word = offs[18:2];

  // Byte-lane bits and high bits fall outside the 17-bit word index.
  assign unused_offs_bits = ^{offs[31:19], offs[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 2'd0;
      op_wr    <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      readData <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Capture the request once; later input changes cannot disturb it.
      if (state == S_IDLE && req) begin
        op_wr   <= wr_en;
        addr_q  <= address;
        wdata_q <= writeData;
      end
      if (state == S_LO && !op_wr) begin
        readData[15:0] <= sram_dq_in;
      end
      if (state == S_HI && !op_wr) begin
        readData[31:16] <= sram_dq_in;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ready       = 1'b0;
    sram_addr   = 18'd0;
    sram_we_n   = 1'b1;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready   = ~req;
        cnt_nxt = 2'd0;
        if (req) begin
          state_nxt = S_LO;
        end
      end
      S_LO: begin
        sram_addr = {word, 1'b0};
        if (op_wr) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[15:0];
        end
        state_nxt = S_HI;
      end
      S_HI: begin
        sram_addr = {word, 1'b1};
        if (op_wr) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[31:16];
        end
        cnt_nxt   = 2'd0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Three recovery cycles: count 0, 1, 2.
        if (cnt == 2'd2) begin
          cnt_nxt   = 2'd0;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
      S_DONE: begin
        // A request held here is deliberately ignored until IDLE.
        ready     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 2'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: directed scenarios plus random loads/stores
// checked against a word-level memory model and a behavioural SRAM.
module tb_sram_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] writeData = 32'd0;
  logic [31:0] readData;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_mem_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .writeData   (writeData),
    .readData    (readData),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_we_n   (sram_we_n),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in)
  );

  // Behavioural SRAM: unwritten cells return an address-derived pattern.
  bit [15:0] sram [0:262143];
  bit        vld  [0:262143];
  logic        pl_en = 1'b0;
  logic [17:0] pl_addr = 18'd0;
  logic [15:0] pl_data = 16'd0;

  function automatic logic [15:0] fill(input logic [17:0] a);
    return a[15:0] ^ {a[17:16], 14'h0} ^ 16'hC3A5;
  endfunction

  assign sram_dq_in = vld[sram_addr] ? sram[sram_addr] : fill(sram_addr);

  always @(posedge clk) begin
    if (!sram_we_n) begin
      sram[sram_addr] <= sram_dq_out;
      vld[sram_addr]  <= 1'b1;
    end
    if (pl_en) begin
      sram[pl_addr] <= pl_data;
      vld[pl_addr]  <= 1'b1;
    end
  end

  // Word-level reference memory and expected readData.
  bit [31:0]   ref_words [int];
  logic [31:0] exp_rd = 32'd0;

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return off[18:2];
  endfunction

  function automatic logic [31:0] ref_load(input logic [16:0] w);
    if (ref_words.exists(int'(w))) return ref_words[int'(w)];
    return {fill({w, 1'b1}), fill({w, 1'b0})};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_addr", 32'(sram_addr), 32'd0);
    chk("idle_we_n", 32'(sram_we_n), 32'd1);
    chk("idle_oe", 32'(sram_dq_oe), 32'd0);
    chk("idle_dq", 32'(sram_dq_out), 32'd0);
    chk("idle_rdata", readData, exp_rd);
  endtask

  // One access from T0 to T6. hold keeps the request asserted in DONE;
  // scramble changes address/data at T2 to prove they were latched.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input bit hold,
                        input bit scramble);
    logic [16:0] w;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    bit          drive;
    w = word_of(a);
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    address = a;
    writeData = d;
    #1;
    chk("t0_ready", 32'(ready), 32'd0);
    chk("t0_rdata", readData, exp_rd);
    if (wr) ref_words[int'(w)] = d;
    else if (rd) exp_rd = ref_load(w);
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      if (scramble && t == 2) begin
        address = $urandom;
        writeData = $urandom;
      end
      if (t == 6 && !hold) begin
        wr_en = 1'b0;
        rd_en = 1'b0;
      end
      #1;
      drive = wr && (t <= 2);
      e_addr = (t == 1) ? {w, 1'b0} : (t == 2) ? {w, 1'b1} : 18'd0;
      e_dq = !drive ? 16'd0 : (t == 1) ? d[15:0] : d[31:16];
      chk($sformatf("t%0d_ready", t), 32'(ready), (t == 6) ? 32'd1 : 32'd0);
      chk($sformatf("t%0d_addr", t), 32'(sram_addr), 32'(e_addr));
      chk($sformatf("t%0d_we_n", t), 32'(sram_we_n), 32'(!drive));
      chk($sformatf("t%0d_oe", t), 32'(sram_dq_oe), 32'(drive));
      chk($sformatf("t%0d_dq", t), 32'(sram_dq_out), 32'(e_dq));
      if (t >= 3) chk($sformatf("t%0d_rdata", t), readData, exp_rd);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [16:0] w;
    int          kind;

    // Reset with a simultaneous request: reset must win.
    wr_en = 1'b1;
    address = 32'd2048;
    @(negedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_rdata", readData, 32'd0);
    rst = 1'b0;
    idle_cycle();

    // Store at the data base.
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b0);
    idle_cycle();

    // Load from preloaded half-words 8 and 9.
    @(negedge clk);
    pl_en = 1'b1;
    pl_addr = 18'd8;
    pl_data = 16'h1234;
    @(negedge clk);
    pl_addr = 18'd9;
    pl_data = 16'hABCD;
    @(negedge clk);
    pl_en = 1'b0;
    ref_words[4] = 32'hABCD1234;
    access(1'b0, 1'b1, 32'd1040, 32'd0, 1'b0, 1'b0);
    chk("load_1040", readData, 32'hABCD1234);
    idle_cycle();

    // Back-to-back loads with rd_en held through DONE.
    access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b1, 1'b0);
    access(1'b0, 1'b1, 32'd1040, 32'd0, 1'b0, 1'b0);
    idle_cycle();

    // Conflict below the base: write wins, address wraps.
    access(1'b1, 1'b1, 32'd1020, 32'h0BADF00D, 1'b0, 1'b0);
    chk("wrap_lo", 32'(sram[18'h3FFFE]), 32'h0000F00D);
    chk("wrap_hi", 32'(sram[18'h3FFFF]), 32'h00000BAD);
    access(1'b0, 1'b1, 32'd1020, 32'd0, 1'b0, 1'b0);
    idle_cycle();

    // Inputs changed mid-store must not matter.
    access(1'b1, 1'b0, 32'd1100, 32'h13579BDF, 1'b0, 1'b1);
    access(1'b0, 1'b1, 32'd1100, 32'd0, 1'b0, 1'b0);

    // Reset during the HI cycle of a store.
    @(negedge clk);
    wr_en = 1'b1;
    address = 32'd1200;
    writeData = 32'hCAFEF00D;
    #1;
    chk("rw_t0_ready", 32'(ready), 32'd0);
    @(negedge clk);
    #1;
    chk("rw_t1_we_n", 32'(sram_we_n), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rw_t2_we_n", 32'(sram_we_n), 32'd0);
    w = word_of(32'd1200);
    ref_words[int'(w)] = 32'hCAFEF00D;
    @(negedge clk);
    rst = 1'b0;
    wr_en = 1'b0;
    exp_rd = 32'd0;
    #1;
    chk("rw_ready", 32'(ready), 32'd1);
    chk("rw_we_n", 32'(sram_we_n), 32'd1);
    chk("rw_oe", 32'(sram_dq_oe), 32'd0);
    chk("rw_addr", 32'(sram_addr), 32'd0);
    chk("rw_rdata", readData, 32'd0);
    access(1'b0, 1'b1, 32'd1040, 32'd0, 1'b0, 1'b0);

    // Random mix over a small window so loads revisit stored words.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        a = 32'd1024 - 32'($urandom_range(1, 16) * 4) + 32'($urandom_range(0, 3));
      else
        a = 32'd1024 + 32'($urandom_range(0, 127));
      kind = int'($urandom_range(0, 4));
      access(kind <= 1, kind >= 1, a, $urandom,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_mem_ctrl.md
SRAM_MEM_CTRL -- requirements
Module: sram_mem_ctrl

Interface
REQ-001 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 Port rst, input, 1: reset, synchronous and active-high.
REQ-003 Port wr_en, input, 1: MEM-stage store request; held stable by the pipeline while ready=0.
REQ-004 Port rd_en, input, 1: MEM-stage load request; held stable by the pipeline while ready=0.
REQ-005 Port address, input, 32: byte address from the EXE ALU result; data memory base is 1024.
REQ-006 Port writeData, input, 32: store data (Val_Rm).
REQ-007 Port readData, output, 32: registered load result.
REQ-008 Port ready, output, 1: access complete; 0 means the pipeline freezes.
REQ-009 Port sram_addr, output, 18: SRAM 16-bit half-word address.
REQ-010 Port sram_we_n, output, 1: SRAM write strobe, active-low.
REQ-011 Port sram_dq_out, output, 16: write data to the SRAM bus.
REQ-012 Port sram_dq_oe, output, 1: 1 means the controller drives the SRAM bus.
REQ-013 Port sram_dq_in, input, 16: read data from the SRAM bus.

Function
REQ-014 FSM states SHALL be IDLE, LO, HI, WAIT, DONE; state and all registers SHALL be clocked.
REQ-015 IDLE: if rd_en|wr_en=1 at a rising edge (cycle T0), the block SHALL latch op (write if wr_en), address and writeData, then go to LO.
REQ-016 If rd_en and wr_en are both 1, the write SHALL take priority.
REQ-017 Transitions SHALL be LO->HI->WAIT; WAIT SHALL last exactly 3 cycles, tracked by a 2-bit counter; then DONE; DONE->IDLE unconditionally.
REQ-018 Total latency SHALL be 6 cycles: T0=IDLE with request, T1=LO, T2=HI, T3-T5=WAIT, T6=DONE.
REQ-019 ready SHALL be combinational:
- 1 in IDLE when rd_en=wr_en=0;
- 0 in IDLE when a request is present;
- 0 in LO, HI and WAIT;
- 1 in DONE.
REQ-020 Requests present in DONE SHALL be ignored. A request seen in the following IDLE cycle SHALL start a new access, so back-to-back accesses cost 7 cycles each.
REQ-021 Word offset SHALL be computed as w = (latched_address - 1024) >> 2, truncated to 17 bits; addresses below 1024 SHALL wrap modulo 2^17 words with no error.
REQ-022 sram_addr SHALL be:
- {w,1'b0} in LO;
- {w,1'b1} in HI;
- 0 in all other states.
REQ-023 Write, LO: sram_we_n=0, sram_dq_oe=1, sram_dq_out=latched writeData[15:0].
REQ-024 Write, HI: sram_we_n=0, sram_dq_oe=1, sram_dq_out=latched writeData[31:16].
REQ-025 In all other states and for reads: sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
REQ-026 Read: readData[15:0] SHALL load sram_dq_in at the edge ending LO, and readData[31:16] at the edge ending HI.
REQ-027 readData SHALL be valid from T3 and held until the next read overwrites it; writes SHALL leave readData unchanged.
REQ-028 Input changes after T0 SHALL NOT affect the access in progress.

Reset
REQ-029 rst=1 at a rising edge SHALL force: state=IDLE, counter=0, readData=0, latched op/address/data=0.
REQ-030 After reset, with no request: ready=1, sram_we_n=1, sram_dq_oe=0, sram_addr=0.
REQ-031 Reset in any state, including mid-write in LO/HI, SHALL abort the access. sram_we_n SHALL be 1 from the cycle after the reset edge.
REQ-032 rst SHALL take precedence over any simultaneous request.

Verification
REQ-033 Store: wr_en=1, address=1024, writeData=0xDEADBEEF -> T1: sram_addr=0, dq_out=0xBEEF, we_n=0. T2: sram_addr=1, dq_out=0xDEAD, we_n=0. ready=0 T0-T5, ready=1 T6.
REQ-034 Load: SRAM model holds 0x1234 at half-address 8 and 0xABCD at half-address 9; rd_en=1, address=1040 -> sram_addr 8 then 9, we_n=1 throughout, readData=0xABCD1234 at T3, ready=1 only at T6.
REQ-035 Back-to-back: two loads with rd_en held across DONE -> second access begins at T7, second ready pulse at T13, single-cycle ready pulses.
REQ-036 Conflict/wrap: rd_en=wr_en=1, address=1020 -> write performed at sram_addr 0x3FFFE/0x3FFFF, readData unchanged.
REQ-037 Reset mid-write: rst=1 during T2 -> next cycle state IDLE, we_n=1, dq_oe=0, readData=0; a subsequent load completes in 6 cycles.
REQ-038 Input hold: change address and writeData at T2 of a store -> SRAM still sees the T0 values.
